// File: rtl/pipe_pkg.sv
// Shared types and widths for the pipeline controller: state encoding,
// register-index and counter widths, and the bundle of control strobes.
package pipe_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        TRAP  = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic pc_stall;
        logic stall_ifid;
        logic flush_ifid;
        logic stall_idex;
        logic flush_idex;
        logic stall_exmem;
        logic flush_exmem;
        logic flush_memwb;
        logic redirect_trap;
    } pipe_ctl_t;

    // Freeze everything up to EX/MEM and drop a bubble into MEM/WB.
    function automatic pipe_ctl_t ctl_dwait();
        pipe_ctl_t c;
        c             = '0;
        c.pc_stall    = 1'b1;
        c.stall_ifid  = 1'b1;
        c.stall_idex  = 1'b1;
        c.stall_exmem = 1'b1;
        c.flush_memwb = 1'b1;
        return c;
    endfunction

    // Kill the three younger instructions and steer fetch to the trap vector.
    function automatic pipe_ctl_t ctl_trap();
        pipe_ctl_t c;
        c               = '0;
        c.flush_ifid    = 1'b1;
        c.flush_idex    = 1'b1;
        c.flush_exmem   = 1'b1;
        c.redirect_trap = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the ID sources and the load destination in EX.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic             rs1_used,
    input  logic             rs2_used,
    input  logic [REG_W-1:0] rd_ex,
    input  logic             mem_read_ex,
    output logic             load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = rs1_used && (rs1 == rd_ex);
    assign rs2_hit  = rs2_used && (rs2 == rd_ex);
    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign load_use = mem_read_ex && (rd_ex != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller for a 5-stage core.
// Optional performance counters are built in when PIPE_CTRL_PERF_EN is defined.
//
// state | meaning
// RUN   | normal flow; trap > dmem wait > branch > load-use > imem wait
// DWAIT | data memory busy; freeze up to EX/MEM until dmem_ready
// TRAP  | one cycle after a trap; drop the instruction fetched meanwhile
module pipe_ctrl
    import pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs1_ID,
    input  logic [REG_W-1:0] rs2_ID,
    input  logic             rs1_used_ID,
    input  logic             rs2_used_ID,
    input  logic [REG_W-1:0] rd_EX,
    input  logic             mem_read_EX,
    input  logic             branch_taken_EX,
    input  logic             imem_ready,
    input  logic             dmem_req_MEM,
    input  logic             dmem_ready,
    input  logic             trap_MEM,
    output logic             pc_stall,
    output logic             stall_IFID,
    output logic             flush_IFID,
    output logic             stall_IDEX,
    output logic             flush_IDEX,
    output logic             stall_EXMEM,
    output logic             flush_EXMEM,
    output logic             flush_MEMWB,
    output logic             redirect_trap
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
`endif
);

    pipe_state_t state;
    pipe_state_t state_nxt;
    pipe_ctl_t   ctl;
    logic        load_use;

    hazard_detect u_hazard (
        .rs1         (rs1_ID),
        .rs2         (rs2_ID),
        .rs1_used    (rs1_used_ID),
        .rs2_used    (rs2_used_ID),
        .rd_ex       (rd_EX),
        .mem_read_ex (mem_read_EX),
        .load_use    (load_use)
    );

    always_comb begin
        ctl       = '0;
        state_nxt = state;
        if (!rst) begin
            unique case (state)
                RUN: begin
                    if (trap_MEM) begin
                        ctl       = ctl_trap();
                        state_nxt = TRAP;
                    end else if (dmem_req_MEM && !dmem_ready) begin
                        ctl       = ctl_dwait();
                        state_nxt = DWAIT;
                    end else if (branch_taken_EX) begin
                        ctl.flush_ifid = 1'b1;
                        ctl.flush_idex = 1'b1;
                    end else if (load_use) begin
                        ctl.pc_stall   = 1'b1;
                        ctl.stall_ifid = 1'b1;
                        ctl.flush_idex = 1'b1;
                    end else if (!imem_ready) begin
                        ctl.pc_stall   = 1'b1;
                        ctl.flush_ifid = 1'b1;
                    end
                end
                DWAIT: begin
                    // A branch in EX is left for the first RUN cycle after exit.
                    if (!dmem_ready) begin
                        ctl = ctl_dwait();
                    end else if (trap_MEM) begin
                        ctl       = ctl_trap();
                        state_nxt = TRAP;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                TRAP: begin
                    ctl.flush_ifid = 1'b1;
                    state_nxt      = RUN;
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // A frozen register must keep its contents, so a stall masks any flush.
    assign pc_stall      = ctl.pc_stall;
    assign stall_IFID    = ctl.stall_ifid;
    assign flush_IFID    = ctl.flush_ifid & ~ctl.stall_ifid;
    assign stall_IDEX    = ctl.stall_idex;
    assign flush_IDEX    = ctl.flush_idex & ~ctl.stall_idex;
    assign stall_EXMEM   = ctl.stall_exmem;
    assign flush_EXMEM   = ctl.flush_exmem & ~ctl.stall_exmem;
    assign flush_MEMWB   = ctl.flush_memwb;
    assign redirect_trap = ctl.redirect_trap;

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (pc_stall) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (flush_IDEX || flush_EXMEM) begin
                flush_events <= flush_events + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model.
module tb_pipe_ctrl;

    typedef struct packed {
        logic pc_stall;
        logic stall_ifid;
        logic flush_ifid;
        logic stall_idex;
        logic flush_idex;
        logic stall_exmem;
        logic flush_exmem;
        logic flush_memwb;
        logic redirect_trap;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs1_ID = '0, rs2_ID = '0, rd_EX = '0;
    logic       rs1_used_ID = 1'b0, rs2_used_ID = 1'b0;
    logic       mem_read_EX = 1'b0, branch_taken_EX = 1'b0;
    logic       imem_ready = 1'b1, dmem_req_MEM = 1'b0, dmem_ready = 1'b0, trap_MEM = 1'b0;
    logic       pc_stall, stall_IFID, flush_IFID, stall_IDEX, flush_IDEX;
    logic       stall_EXMEM, flush_EXMEM, flush_MEMWB, redirect_trap;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles, flush_events;
`endif

    int n_pass  = 0;
    int n_total = 0;

    pipe_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .rs1_ID          (rs1_ID),
        .rs2_ID          (rs2_ID),
        .rs1_used_ID     (rs1_used_ID),
        .rs2_used_ID     (rs2_used_ID),
        .rd_EX           (rd_EX),
        .mem_read_EX     (mem_read_EX),
        .branch_taken_EX (branch_taken_EX),
        .imem_ready      (imem_ready),
        .dmem_req_MEM    (dmem_req_MEM),
        .dmem_ready      (dmem_ready),
        .trap_MEM        (trap_MEM),
        .pc_stall        (pc_stall),
        .stall_IFID      (stall_IFID),
        .flush_IFID      (flush_IFID),
        .stall_IDEX      (stall_IDEX),
        .flush_IDEX      (flush_IDEX),
        .stall_EXMEM     (stall_EXMEM),
        .flush_EXMEM     (flush_EXMEM),
        .flush_MEMWB     (flush_MEMWB),
        .redirect_trap   (redirect_trap)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
`endif
    );

    always #5 clk = ~clk;

    function automatic outs_t dut_outs();
        return {pc_stall, stall_IFID, flush_IFID, stall_IDEX, flush_IDEX,
                stall_EXMEM, flush_EXMEM, flush_MEMWB, redirect_trap};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // Model: "waiting" = a data access is outstanding, "after_trap" = last cycle took a trap.
    bit          m_waiting    = 1'b0;
    bit          m_after_trap = 1'b0;
    logic [31:0] m_stalls     = '0;
    logic [31:0] m_flushes    = '0;

    function automatic outs_t model_outs(bit waiting, bit after_trap);
        outs_t o = '0;
        bit hazard;
        hazard = mem_read_EX && rd_EX != 0 &&
                 ((rs1_used_ID && rs1_ID == rd_EX) || (rs2_used_ID && rs2_ID == rd_EX));
        if (rst) return o;
        if (after_trap) begin
            o.flush_ifid = 1;
        end else if (waiting) begin
            if (!dmem_ready) o = 9'b110101010;
            else if (trap_MEM) o = 9'b001010101;
        end else if (trap_MEM) o = 9'b001010101;
        else if (dmem_req_MEM && !dmem_ready) o = 9'b110101010;
        else if (branch_taken_EX) o = 9'b001010000;
        else if (hazard) o = 9'b110010000;
        else if (!imem_ready) o = 9'b101000000;
        return o;
    endfunction

    // Single compare process: every falling edge the outputs are meaningful.
    always @(negedge clk) begin
        outs_t e;
        e = model_outs(m_waiting, m_after_trap);
        check("outs_vs_model", 32'(dut_outs()), 32'(e));
`ifdef PIPE_CTRL_PERF_EN
        check("stall_cycles_vs_model", stall_cycles, m_stalls);
        check("flush_events_vs_model", flush_events, m_flushes);
`endif
        if (rst) begin
            m_waiting = 0; m_after_trap = 0; m_stalls = '0; m_flushes = '0;
        end else begin
            if (e.pc_stall) m_stalls++;
            if (e.flush_idex || e.flush_exmem) m_flushes++;
            if (m_after_trap) begin
                m_after_trap = 0;
            end else if (m_waiting) begin
                m_waiting    = !dmem_ready;
                m_after_trap = dmem_ready && trap_MEM;
            end else begin
                m_after_trap = trap_MEM;
                m_waiting    = !trap_MEM && dmem_req_MEM && !dmem_ready;
            end
        end
    end

    task automatic cyc();  @(posedge clk); #1; endtask
    task automatic samp(); @(negedge clk); #1; endtask

    task automatic idle();
        rs1_ID = 0; rs2_ID = 0; rd_EX = 0; rs1_used_ID = 0; rs2_used_ID = 0;
        mem_read_EX = 0; branch_taken_EX = 0; imem_ready = 1;
        dmem_req_MEM = 0; dmem_ready = 0; trap_MEM = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        samp(); check("reset_outs", 32'(dut_outs()), 32'h0);
        cyc(); rst = 0;

        mem_read_EX = 1; rd_EX = 5; rs1_ID = 5; rs1_used_ID = 1;
        samp(); check("load_use_x5", 32'(dut_outs()), 32'(9'b110010000));
        cyc(); idle();
        samp(); check("load_use_after", 32'(dut_outs()), 32'h0);

        cyc(); mem_read_EX = 1; rd_EX = 0; rs1_ID = 0; rs1_used_ID = 1;
        samp(); check("load_x0_no_stall", 32'(dut_outs()), 32'h0);

        cyc(); idle(); dmem_req_MEM = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            samp(); check("dwait_stall", 32'(dut_outs()), 32'(9'b110101010));
            check("dwait_stall_exmem", 32'(stall_EXMEM), 32'h1);
            cyc(); branch_taken_EX = 1;
        end
        dmem_ready = 1;
        samp(); check("dwait_exit", 32'(dut_outs()), 32'h0);
        cyc(); dmem_req_MEM = 0; dmem_ready = 0;
        samp(); check("branch_after_dwait", 32'(dut_outs()), 32'(9'b001010000));

        cyc(); idle(); branch_taken_EX = 1; mem_read_EX = 1; rd_EX = 7; rs2_ID = 7; rs2_used_ID = 1;
        samp(); check("branch_over_load_use", 32'(dut_outs()), 32'(9'b001010000));
        check("branch_no_pc_stall", 32'(pc_stall), 32'h0);

        cyc(); idle(); trap_MEM = 1;
        samp(); check("trap_run", 32'(dut_outs()), 32'(9'b001010101));
        cyc(); trap_MEM = 0;
        samp(); check("trap_next", 32'(dut_outs()), 32'(9'b001000000));
        cyc();
        samp(); check("trap_done", 32'(dut_outs()), 32'h0);

        cyc(); imem_ready = 0;
        samp(); check("imem_bubble", 32'(dut_outs()), 32'(9'b101000000));

        cyc(); idle(); dmem_req_MEM = 1;
        samp(); check("pre_rst_dwait", 32'(dut_outs()), 32'(9'b110101010));
        cyc(); rst = 1; #1;
        check("rst_in_dwait", 32'(dut_outs()), 32'h0);
        cyc(); rst = 0; dmem_req_MEM = 0; branch_taken_EX = 1;
        samp(); check("post_rst_run", 32'(dut_outs()), 32'(9'b001010000));

`ifdef PIPE_CTRL_PERF_EN
        cyc(); idle(); rst = 1;
        cyc(); rst = 0; imem_ready = 0;
        repeat (4) cyc();
        imem_ready = 1;
        samp(); check("perf_stall_cycles_4", stall_cycles, 32'd4);
`endif

        for (int n = 0; n < 3000; n++) begin
            cyc();
            rst             = ($urandom_range(0, 99) == 0);
            rs1_ID          = 5'($urandom_range(0, 3));
            rs2_ID          = 5'($urandom_range(0, 3));
            rd_EX           = 5'($urandom_range(0, 3));
            rs1_used_ID     = ($urandom_range(0, 1) == 1);
            rs2_used_ID     = ($urandom_range(0, 1) == 1);
            mem_read_EX     = ($urandom_range(0, 1) == 1);
            branch_taken_EX = ($urandom_range(0, 6) == 0);
            imem_ready      = ($urandom_range(0, 4) != 0);
            dmem_req_MEM    = ($urandom_range(0, 2) == 0);
            dmem_ready      = ($urandom_range(0, 1) == 1);
            trap_MEM        = ($urandom_range(0, 19) == 0);
        end
        cyc(); idle(); rst = 0;
        samp();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
